// File: rtl/ex7_pkg.sv
// Shared mode encodings and reset constant for the ex7 LED pattern generator.
package ex7_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL  = 2'b00,
        MODE_ROTR  = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    localparam logic [7:0] LED_RESET = 8'h01;

endpackage

// File: rtl/ex7_tick_gen.sv
// Prescaler for ex7: counts 0..PRESCALE-1 and flags the last count as a one-cycle step tick.
module ex7_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A one-bit counter still works for PRESCALE == 1, where it simply stays at zero.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;

    assign tick = (cnt_r == LAST);

    // Free-running prescale counter, wrapping after the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ex7.sv
// ex7 LED pattern generator: four switch-selected animations on an 8-bit LED register.
// Define EX7_PRESCALE_EN to step only every PRESCALE clock edges instead of every edge.
module ex7
    import ex7_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] SW,
    output logic [7:0] LED
);

    logic       tick_s;
    logic [7:0] led_next_s;
    mode_e      mode_s;

    assign mode_s = mode_e'(SW);

`ifdef EX7_PRESCALE_EN
    ex7_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (Clk),
        .rst (Rst),
        .tick(tick_s)
    );
`else
    // Every edge steps; the expression holds for every legal PRESCALE.
    assign tick_s = (PRESCALE >= 1) ? 1'b1 : 1'b0;
`endif

    // Next pattern value; rotate modes reseed a dark display instead of rotating zeros.
    always_comb begin
        led_next_s = LED;
        case (mode_s)
            MODE_ROTL: begin
                if (LED == 8'h00) begin
                    led_next_s = LED_RESET;
                end else begin
                    led_next_s = {LED[6:0], LED[7]};
                end
            end
            MODE_ROTR: begin
                if (LED == 8'h00) begin
                    led_next_s = LED_RESET;
                end else begin
                    led_next_s = {LED[0], LED[7:1]};
                end
            end
            MODE_COUNT: led_next_s = LED + 8'h01;
            MODE_BLINK: led_next_s = ~LED;
            default:    led_next_s = LED_RESET;
        endcase
    end

    // LED pattern register, advanced only on step edges.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            LED <= LED_RESET;
        end else if (tick_s) begin
            LED <= led_next_s;
        end else begin
            LED <= LED;
        end
    end

endmodule

// File: tb/tb_ex7.sv
// Directed testbench for ex7 (default build): stimulus pushes expected LED values, a monitor compares.
module tb_ex7;

    logic       Clk;
    logic       Rst;
    logic [1:0] SW;
    logic [7:0] LED;

    int n_vec;
    int n_miss;

    logic [7:0] exp_q[$];
    string      name_q[$];
    event       sample_ev;

    ex7 #(.PRESCALE(1)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .SW (SW),
        .LED(LED)
    );

    task automatic edge_clk();
        #5 Clk = 1'b1;
        #5 Clk = 1'b0;
    endtask

    task automatic expect_led(input string name, input logic [7:0] val);
        exp_q.push_back(val);
        name_q.push_back(name);
        -> sample_ev;
        #2;
    endtask

    task automatic step_expect(input string name, input logic [7:0] val);
        edge_clk();
        expect_led(name, val);
    endtask

    // Monitor: compares LED against the oldest queued expectation.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(sample_ev);
            #1;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (LED !== e) begin
                n_miss++;
                $display("FAIL %s: LED=%h expected %h", nm, LED, e);
            end
        end
    end

    initial begin
        logic [7:0] rotl_tab[8];
        logic [7:0] rotr_tab[3];
        n_vec  = 0;
        n_miss = 0;
        Clk = 1'b0;
        Rst = 1'b0;
        SW  = 2'b00;
        rotl_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        rotr_tab = '{8'h01, 8'h80, 8'h40};

        #3 Rst = 1'b1;
        expect_led("reset_async", 8'h01);
        Rst = 1'b0;
        #5;
        expect_led("reset_release_no_edge", 8'h01);

        SW = 2'b00;
        for (int i = 0; i < 8; i++) step_expect("rotl", rotl_tab[i]);

        step_expect("rotl_to_02", 8'h02);
        SW = 2'b01;
        for (int i = 0; i < 3; i++) step_expect("rotr", rotr_tab[i]);

        SW = 2'b10;
        for (int i = 0; i < 190; i++) edge_clk();
        expect_led("count_load_fe", 8'hFE);
        step_expect("count_ff", 8'hFF);
        step_expect("count_wrap", 8'h00);
        SW = 2'b00;
        step_expect("rotl_dark_recover", 8'h01);

        SW = 2'b11;
        step_expect("blink_1", 8'hFE);
        step_expect("blink_2", 8'h01);

        SW = 2'b00; #2;
        SW = 2'b01; #2;
        SW = 2'b10; #2;
        SW = 2'b11; #2;
        expect_led("sw_toggle_no_edge", 8'h01);

        step_expect("blink_3", 8'hFE);
        SW = 2'b10;
        step_expect("count_ff_2", 8'hFF);
        step_expect("count_wrap_2", 8'h00);
        SW = 2'b01;
        step_expect("rotr_dark_recover", 8'h01);
        SW = 2'b10;
        step_expect("count_02", 8'h02);
        step_expect("count_03", 8'h03);

        Rst = 1'b1;
        #1;
        expect_led("reset_mid_pattern", 8'h01);
        step_expect("reset_held_over_edge", 8'h01);
        Rst = 1'b0;
        #2;
        step_expect("first_step_after_reset", 8'h02);

        #5;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
